// File: rtl/hba_arbiter.sv
// hba_arbiter: round-robin arbiter that shares the HBA bus between
// NUM_MASTERS bus masters. Grants are registered and one-hot. The granted
// master's address, rnw, select and write data are AND-OR multiplexed onto
// the shared slave bus. With no grant held, every bus output is zero.
//
// Optional feature (compile-time macro HBA_ARB_TIMEOUT_EN):
//   A watchdog revokes a grant after TIMEOUT_CYCLES grant cycles without
//   hba_xferack and pulses arb_timeout for one cycle. Without the macro,
//   arb_timeout is tied low and hba_xferack is ignored.
//
// Ports:
//   hba_clk         bus clock, rising edge
//   hba_reset       synchronous active-high reset
//   master_request  per-master bus request
//   master_abus     packed per-master addresses (ADDR_WIDTH each)
//   master_rnw      per-master read-not-write
//   master_select   per-master transfer-in-progress
//   master_dbus     packed per-master write data (DBUS_WIDTH each)
//   hba_xferack     slave transfer-complete (watchdog only)
//   hba_mgrant      one-hot registered grant
//   hba_abus        address of the granted master
//   hba_rnw         rnw of the granted master
//   hba_select      select of the granted master
//   hba_mdbus       write data of the granted master
//   arb_busy        high while a grant is held
//   arb_owner       index of the current or last owner
//   arb_timeout     one-cycle watchdog pulse
module hba_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DBUS_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                              hba_clk,
  input  logic                              hba_reset,
  input  logic [NUM_MASTERS-1:0]            master_request,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus,
  input  logic [NUM_MASTERS-1:0]            master_rnw,
  input  logic [NUM_MASTERS-1:0]            master_select,
  input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus,
  input  logic                              hba_xferack,
  output logic [NUM_MASTERS-1:0]            hba_mgrant,
  output logic [ADDR_WIDTH-1:0]             hba_abus,
  output logic                              hba_rnw,
  output logic                              hba_select,
  output logic [DBUS_WIDTH-1:0]             hba_mdbus,
  output logic                              arb_busy,
  output logic [2:0]                        arb_owner,
  output logic                              arb_timeout
);

  localparam int unsigned OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [OW-1:0]          last_q, last_d;
  logic                   timeout_q, timeout_d;

  logic                   win_found;
  logic [OW-1:0]          win_idx;
  logic                   owner_req;
  logic                   wd_expire;

`ifdef HBA_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;

  // Expire in the grant cycle that would bring the count to the limit;
  // an xferack in that same cycle wins and clears the count instead.
  assign wd_expire = (state_q == GRANT) && !hba_xferack &&
                     (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d = '0;
    if (state_q == GRANT && !hba_xferack)
      wd_cnt_d = wd_cnt_q + 16'd1;
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) wd_cnt_q <= '0;
    else           wd_cnt_q <= wd_cnt_d;
  end
`else
  logic unused_xferack;
  assign unused_xferack = hba_xferack | (TIMEOUT_CYCLES == 0);
  assign wd_expire      = 1'b0;
`endif

  assign owner_req = master_request[owner_q];

  // Round-robin scan: first requester strictly after the last owner,
  // wrapping, so the last owner itself is considered last.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx = (32'(last_q) + k) % NUM_MASTERS;
      if (!win_found && master_request[idx[OW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[OW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= OW'(NUM_MASTERS - 1);
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          for (int unsigned i = 0; i < NUM_MASTERS; i++)
            grant_d[i] = (OW'(i) == win_idx);
          owner_d = win_idx;
          last_d  = win_idx;
        end
      end
      GRANT: begin
        if (!owner_req || wd_expire) begin
          state_d   = IDLE;
          grant_d   = '0;
          // A normal release in the expiry cycle is not a timeout.
          timeout_d = owner_req;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output logic: registered status plus AND-OR bus multiplexer
  always_comb begin
    hba_mgrant  = grant_q;
    arb_busy    = (state_q == GRANT);
    arb_owner   = 3'(owner_q);
    arb_timeout = timeout_q;
    hba_abus    = '0;
    hba_rnw     = 1'b0;
    hba_select  = 1'b0;
    hba_mdbus   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      hba_abus   = hba_abus   | ({ADDR_WIDTH{grant_q[i]}} & master_abus[i*ADDR_WIDTH +: ADDR_WIDTH]);
      hba_rnw    = hba_rnw    | (grant_q[i] & master_rnw[i]);
      hba_select = hba_select | (grant_q[i] & master_select[i]);
      hba_mdbus  = hba_mdbus  | ({DBUS_WIDTH{grant_q[i]}} & master_dbus[i*DBUS_WIDTH +: DBUS_WIDTH]);
    end
  end

endmodule

// File: tb/tb_hba_arbiter.sv
module tb_hba_arbiter;

  localparam int NM = 2;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 8;

  logic           clk;
  logic           rst;
  logic [NM-1:0]  req;
  logic [NM*AW-1:0] abus;
  logic [NM-1:0]  rnw;
  logic [NM-1:0]  sel;
  logic [NM*DW-1:0] dbus;
  logic           xack;
  logic [NM-1:0]  mgrant;
  logic [AW-1:0]  o_abus;
  logic           o_rnw;
  logic           o_sel;
  logic [DW-1:0]  o_dbus;
  logic           busy;
  logic [2:0]     owner;
  logic           tout;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: who holds the bus, who had it last.
  bit m_held;
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_to;

  hba_arbiter #(
    .NUM_MASTERS(NM),
    .DBUS_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .hba_clk(clk),
    .hba_reset(rst),
    .master_request(req),
    .master_abus(abus),
    .master_rnw(rnw),
    .master_select(sel),
    .master_dbus(dbus),
    .hba_xferack(xack),
    .hba_mgrant(mgrant),
    .hba_abus(o_abus),
    .hba_rnw(o_rnw),
    .hba_select(o_sel),
    .hba_mdbus(o_dbus),
    .arb_busy(busy),
    .arb_owner(owner),
    .arb_timeout(tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_next();
    if (rst) begin
      m_held = 0; m_owner = 0; m_last = NM - 1; m_to = 0; m_cnt = 0;
    end else if (!m_held) begin
      m_to = 0;
      for (int k = 1; k <= NM; k++) begin
        int i;
        i = (m_last + k) % NM;
        if (req[i]) begin
          m_held = 1; m_owner = i; m_last = i; m_cnt = 0;
          break;
        end
      end
    end else begin
      m_to = 0;
      if (!req[m_owner]) m_held = 0;
`ifdef HBA_ARB_TIMEOUT_EN
      else if (xack) m_cnt = 0;
      else if (m_cnt + 1 == TO) begin
        m_held = 0;
        m_to   = 1;
      end else m_cnt++;
`endif
    end
  endtask

  task automatic compare_model();
    logic [NM-1:0] one;
    logic [NM-1:0] eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          er, es;
    one = 1;
    eg = '0; ea = '0; ed = '0; er = 0; es = 0;
    if (m_held) begin
      eg = one << m_owner;
      ea = abus[m_owner*AW +: AW];
      ed = dbus[m_owner*DW +: DW];
      er = rnw[m_owner];
      es = sel[m_owner];
    end
    chk("model_grant",   32'(mgrant), 32'(eg));
    chk("model_owner",   32'(owner),  32'(m_owner));
    chk("model_busy",    32'(busy),   32'(m_held));
    chk("model_timeout", 32'(tout),   32'(m_to));
    chk("model_abus",    32'(o_abus), 32'(ea));
    chk("model_rnw",     32'(o_rnw),  32'(er));
    chk("model_select",  32'(o_sel),  32'(es));
    chk("model_mdbus",   32'(o_dbus), 32'(ed));
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1; req = '0; xack = 0;
    step();
    rst = 0;
  endtask

  typedef struct {
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    sel;
    logic [11:0]   a0;
    logic [11:0]   a1;
    logic [1:0]    exp_grant;
    logic [2:0]    exp_owner;
    logic [11:0]   exp_abus;
    logic          exp_sel;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int gcnt;
    bit seen;
    logic [1:0] expg;
    rst = 1; req = '0; abus = '0; rnw = '0; sel = '0; dbus = '0; xack = 0;
    m_held = 0; m_owner = 0; m_last = NM - 1; m_cnt = 0; m_to = 0;

    // Table-driven directed vectors (inputs applied, then one clock edge)
    tbl[0]  = '{1'b1, 2'b00, 2'b00, 12'h000, 12'h000, 2'b00, 3'd0, 12'h000, 1'b0};
    tbl[1]  = '{1'b0, 2'b01, 2'b01, 12'h123, 12'h000, 2'b01, 3'd0, 12'h123, 1'b1};
    tbl[2]  = '{1'b0, 2'b00, 2'b01, 12'h123, 12'h000, 2'b00, 3'd0, 12'h000, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 2'b10, 12'h000, 12'hFFF, 2'b00, 3'd0, 12'h000, 1'b0};
    tbl[4]  = '{1'b0, 2'b11, 2'b10, 12'h123, 12'hFFF, 2'b10, 3'd1, 12'hFFF, 1'b1};
    tbl[5]  = '{1'b0, 2'b01, 2'b11, 12'h0AA, 12'hFFF, 2'b00, 3'd1, 12'h000, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 2'b11, 12'h0AA, 12'hFFF, 2'b01, 3'd0, 12'h0AA, 1'b1};
    tbl[7]  = '{1'b0, 2'b11, 2'b10, 12'h0AA, 12'h555, 2'b01, 3'd0, 12'h0AA, 1'b0};
    tbl[8]  = '{1'b0, 2'b10, 2'b10, 12'h0AA, 12'h555, 2'b00, 3'd0, 12'h000, 1'b0};
    tbl[9]  = '{1'b0, 2'b10, 2'b10, 12'h0AA, 12'h555, 2'b10, 3'd1, 12'h555, 1'b1};
    tbl[10] = '{1'b1, 2'b11, 2'b10, 12'h0AA, 12'h555, 2'b00, 3'd0, 12'h000, 1'b0};
    tbl[11] = '{1'b0, 2'b11, 2'b11, 12'h321, 12'h555, 2'b01, 3'd0, 12'h321, 1'b1};
    tbl[12] = '{1'b0, 2'b10, 2'b11, 12'h321, 12'h555, 2'b00, 3'd0, 12'h000, 1'b0};
    tbl[13] = '{1'b0, 2'b10, 2'b11, 12'h321, 12'h555, 2'b10, 3'd1, 12'h555, 1'b1};

    for (int v = 0; v < 14; v++) begin
      rst  = tbl[v].rst;
      req  = tbl[v].req;
      sel  = tbl[v].sel;
      abus = {tbl[v].a1, tbl[v].a0};
      step();
      chk($sformatf("tbl%0d_grant", v), 32'(mgrant), 32'(tbl[v].exp_grant));
      chk($sformatf("tbl%0d_owner", v), 32'(owner),  32'(tbl[v].exp_owner));
      chk($sformatf("tbl%0d_busy", v),  32'(busy),   32'(tbl[v].exp_grant != 2'b00));
      chk($sformatf("tbl%0d_abus", v),  32'(o_abus), 32'(tbl[v].exp_abus));
      chk($sformatf("tbl%0d_sel", v),   32'(o_sel),  32'(tbl[v].exp_sel));
    end
    rst = 0;

    // Both requesting; each owner releases after 4 granted cycles
    do_reset();
    req = 2'b11;
    for (int c = 0; c < 40; c++) begin
      step();
      if (c % 10 < 4)       expg = 2'b01;
      else if (c % 10 < 5)  expg = 2'b00;
      else if (c % 10 < 9)  expg = 2'b10;
      else                  expg = 2'b00;
      chk($sformatf("alt%0d_grant", c), 32'(mgrant), 32'(expg));
      req = 2'b11;
      if (c % 10 == 3) req[0] = 1'b0;
      if (c % 10 == 8) req[1] = 1'b0;
    end

`ifdef HBA_ARB_TIMEOUT_EN
    // Master 0 holds the bus with no xferack: watchdog revokes it
    do_reset();
    req = 2'b01; xack = 0;
    gcnt = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (mgrant == 2'b01) gcnt++;
      if (tout) begin
        seen = 1;
        chk("wd_grant_revoked", 32'(mgrant), 32'(0));
      end
    end
    chk("wd_seen", 32'(seen), 32'(1));
    chk("wd_grant_cycles", 32'(gcnt), 32'(TO));
    req = 2'b11;
    step();
    chk("wd_pulse_one_cycle", 32'(tout), 32'(0));
    chk("wd_next_owner", 32'(mgrant), 32'(2'b10));

    // Periodic xferack keeps the watchdog quiet
    do_reset();
    req = 2'b01;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      xack = (c % 5 == 4);
      step();
      if (tout) seen = 1;
    end
    chk("wd_ack_no_timeout", 32'(seen), 32'(0));
    xack = 0;
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NM; i++)
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
      rst  = ($urandom_range(0, 99) == 0);
      xack = ($urandom_range(0, 11) == 0);
      abus = (NM*AW)'($urandom);
      dbus = (NM*DW)'($urandom);
      rnw  = NM'($urandom);
      sel  = NM'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
